// File: rtl/axis_lane_distributor.sv
// Fans one wide AXI-Stream beat out into LANES independent per-lane FIFOs,
// generating per-vector tlast and flagging upstream tlast misalignment.
module axis_lane_distributor #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned VECTOR_LENGTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [LANES*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [LANES-1:0]              m_axis_tvalid,
    input  logic [LANES-1:0]              m_axis_tready,
    output logic [LANES-1:0]              m_axis_tlast,
    output logic                          err_unalligned_data
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BCNT_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(VECTOR_LENGTH - 1);

    logic [DATA_WIDTH-1:0] mem_data_q [LANES][FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q [LANES];

    logic [PTR_W-1:0]  wr_ptr_q [LANES];
    logic [PTR_W-1:0]  wr_ptr_d [LANES];
    logic [PTR_W-1:0]  rd_ptr_q [LANES];
    logic [PTR_W-1:0]  rd_ptr_d [LANES];
    logic [CNT_W-1:0]  cnt_q    [LANES];
    logic [CNT_W-1:0]  cnt_d    [LANES];
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              err_q, err_d;

    logic              any_full_c;
    logic              push_c;
    logic              gen_last_c;
    logic [LANES-1:0]  pop_c;

    // Input is stalled whenever any single lane is full, so lanes never diverge.
    always_comb begin
        any_full_c = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (cnt_q[k] == FULL_CNT) begin
                any_full_c = 1'b1;
            end
        end
    end

    assign s_axis_tready       = rst_n & ~any_full_c;
    assign push_c              = s_axis_tvalid & s_axis_tready;
    assign gen_last_c          = (bcnt_q == LAST_BEAT);
    assign err_unalligned_data = err_q;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            m_axis_tvalid[k]                         = (cnt_q[k] != '0);
            m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = mem_data_q[k][rd_ptr_q[k]];
            m_axis_tlast[k]                          = (cnt_q[k] != '0) & mem_last_q[k][rd_ptr_q[k]];
            pop_c[k]                                 = (cnt_q[k] != '0) & m_axis_tready[k];
        end
    end

    // Next-state: beat counter, error pulse and per-lane pointers/counts.
    always_comb begin
        bcnt_d   = bcnt_q;
        err_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push_c) begin
            bcnt_d = (gen_last_c | s_axis_tlast) ? '0 : bcnt_q + BCNT_W'(1);
            err_d  = gen_last_c ^ s_axis_tlast;
        end

        for (int k = 0; k < LANES; k++) begin
            if (push_c) begin
                wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
            end
            if (pop_c[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            end
            case ({push_c, pop_c[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            bcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            for (int k = 0; k < LANES; k++) begin
                mem_data_q[k][wr_ptr_q[k]] <= s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                mem_last_q[k][wr_ptr_q[k]] <= gen_last_c;
            end
        end
    end

endmodule

// File: tb/tb_axis_lane_distributor.sv
// Self-checking bench for axis_lane_distributor: directed vector table,
// hand sequences for stall/reset corners, and a randomized model-checked run.
module tb_axis_lane_distributor;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int VL    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [LANES*DW-1:0]   s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [LANES*DW-1:0]   m_axis_tdata;
    logic [LANES-1:0]      m_axis_tvalid;
    logic [LANES-1:0]      m_axis_tready;
    logic [LANES-1:0]      m_axis_tlast;
    logic                  err;

    always #5 clk = ~clk;

    axis_lane_distributor #(
        .LANES(LANES), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .VECTOR_LENGTH(VL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .err_unalligned_data(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the accepted beat history plus how far each lane has read.
    logic [LANES*DW-1:0] mdata [8192];
    logic                mlast [8192];
    int                  acc;
    int                  cons [LANES];
    int                  pos;
    logic                err_pend;
    int                  hs_cnt;

    typedef struct {
        logic        in_valid;
        logic [15:0] in_base;
        logic        in_last;
        logic        exp_valid;
        logic [15:0] exp_base;
        logic        exp_last;
        logic        exp_err;
    } vec_t;

    localparam int NROWS = 24;
    vec_t tbl [NROWS];

    function automatic vec_t mk(int iv, int ib, int il, int ev, int eb, int el, int ee);
        vec_t r;
        r.in_valid  = (iv != 0);
        r.in_base   = 16'(ib);
        r.in_last   = (il != 0);
        r.exp_valid = (ev != 0);
        r.exp_base  = 16'(eb);
        r.exp_last  = (el != 0);
        r.exp_err   = (ee != 0);
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] pack(logic [15:0] base);
        logic [LANES*DW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(base + 16'(k));
        return v;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        acc = 0;
        pos = 0;
        err_pend = 1'b0;
        for (int k = 0; k < LANES; k++) cons[k] = 0;
    endtask

    function automatic logic model_full();
        for (int k = 0; k < LANES; k++) if (acc - cons[k] == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        logic exp_ready;
        int   occ;
        exp_ready = rst_n && !model_full();
        cmp("s_tready", 0, 32'(s_axis_tready), 32'(exp_ready));
        cmp("err", 0, 32'(err), 32'(err_pend));
        for (int k = 0; k < LANES; k++) begin
            occ = acc - cons[k];
            cmp("m_tvalid", k, 32'(m_axis_tvalid[k]), 32'(occ != 0));
            if (occ != 0) begin
                cmp("m_tdata", k, 32'(m_axis_tdata[k*DW +: DW]), 32'(mdata[cons[k]][k*DW +: DW]));
                cmp("m_tlast", k, 32'(m_axis_tlast[k]), 32'(mlast[cons[k]]));
            end
            if (!rst_n) cmp("m_tlast_rst", k, 32'(m_axis_tlast[k]), 32'd0);
        end
    endtask

    task automatic model_step();
        logic push;
        logic gen;
        if (rst_n) begin
            push = s_axis_tvalid && !model_full();
            for (int k = 0; k < LANES; k++)
                if (acc - cons[k] != 0 && m_axis_tready[k]) cons[k]++;
            gen = (pos == VL - 1);
            err_pend = push && (gen != s_axis_tlast);
            if (push) begin
                mdata[acc] = s_axis_tdata;
                mlast[acc] = gen;
                acc++;
                pos = (gen || s_axis_tlast) ? 0 : pos + 1;
            end
        end
    endtask

    // One clock: inputs were driven at posedge+1; check at +2, then advance.
    task automatic cycle();
        #1;
        if (!rst_n) model_reset();
        check_outputs();
        if (s_axis_tvalid && s_axis_tready) hs_cnt++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = '1;
        cycle();
        cycle();
        rst_n = 1'b1;
        hs_cnt = 0;
    endtask

    task automatic drive_next();
        s_axis_tdata = pack(16'(hs_cnt * 16));
        s_axis_tlast = (pos == VL - 1);
    endtask

    initial begin
        int hs0;
        rst_n = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_tready = '1;
        model_reset();
        hs_cnt = 0;

        // Fan-out, early tlast resync, then missing tlast (lane k word = base + k).
        tbl[0]  = mk(1,   0, 0,  0,   0, 0, 0);
        tbl[1]  = mk(1,  16, 0,  1,   0, 0, 0);
        tbl[2]  = mk(1,  32, 0,  1,  16, 0, 0);
        tbl[3]  = mk(1,  48, 1,  1,  32, 0, 0);
        tbl[4]  = mk(0,   0, 0,  1,  48, 1, 0);
        tbl[5]  = mk(0,   0, 0,  0,   0, 0, 0);
        tbl[6]  = mk(1,  64, 0,  0,   0, 0, 0);
        tbl[7]  = mk(1,  80, 1,  1,  64, 0, 0);
        tbl[8]  = mk(1,  96, 0,  1,  80, 0, 1);
        tbl[9]  = mk(1, 112, 0,  1,  96, 0, 0);
        tbl[10] = mk(1, 128, 0,  1, 112, 0, 0);
        tbl[11] = mk(1, 144, 1,  1, 128, 0, 0);
        tbl[12] = mk(0,   0, 0,  1, 144, 1, 0);
        tbl[13] = mk(0,   0, 0,  0,   0, 0, 0);
        tbl[14] = mk(1, 160, 0,  0,   0, 0, 0);
        tbl[15] = mk(1, 176, 0,  1, 160, 0, 0);
        tbl[16] = mk(1, 192, 0,  1, 176, 0, 0);
        tbl[17] = mk(1, 208, 0,  1, 192, 0, 0);
        tbl[18] = mk(1, 224, 0,  1, 208, 1, 1);
        tbl[19] = mk(1, 240, 0,  1, 224, 0, 0);
        tbl[20] = mk(1, 256, 0,  1, 240, 0, 0);
        tbl[21] = mk(1, 272, 0,  1, 256, 0, 0);
        tbl[22] = mk(0,   0, 0,  1, 272, 1, 1);
        tbl[23] = mk(0,   0, 0,  0,   0, 0, 0);

        #1;
        do_reset();
        for (int i = 0; i < NROWS; i++) begin
            s_axis_tvalid = tbl[i].in_valid;
            s_axis_tdata  = pack(tbl[i].in_base);
            s_axis_tlast  = tbl[i].in_last;
            #1;
            cmp("t_ready", i, 32'(s_axis_tready), 32'd1);
            cmp("t_err", i, 32'(err), 32'(tbl[i].exp_err));
            for (int k = 0; k < LANES; k++) begin
                cmp("t_valid", i, 32'(m_axis_tvalid[k]), 32'(tbl[i].exp_valid));
                if (tbl[i].exp_valid) begin
                    cmp("t_data", i, 32'(m_axis_tdata[k*DW +: DW]), 32'(tbl[i].exp_base + 16'(k)));
                    cmp("t_last", i, 32'(m_axis_tlast[k]), 32'(tbl[i].exp_last));
                end
            end
            @(posedge clk);
            #1;
        end

        // Lane 3 stalled: exactly DEPTH beats accepted, resumes after it pops.
        do_reset();
        m_axis_tready = 4'b0111;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_next();
            cycle();
        end
        cmp("bp_accepted", 0, 32'(hs_cnt), 32'd8);
        cmp("bp_ready_low", 0, 32'(s_axis_tready), 32'd0);
        m_axis_tready = 4'b1111;
        drive_next();
        cycle();
        cmp("bp_no_push_on_pop", 0, 32'(hs_cnt), 32'd8);
        cmp("bp_ready_resume", 0, 32'(s_axis_tready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_next();
            cycle();
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Lane 0 full, single-cycle pop with input pending.
        m_axis_tready = 4'b1110;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_next();
            cycle();
        end
        hs0 = hs_cnt;
        cmp("fp_ready_full", 0, 32'(s_axis_tready), 32'd0);
        m_axis_tready = 4'b1111;
        drive_next();
        cycle();
        cmp("fp_no_push", 0, 32'(hs_cnt - hs0), 32'd0);
        m_axis_tready = 4'b1110;
        cmp("fp_ready_one_slot", 0, 32'(s_axis_tready), 32'd1);
        drive_next();
        cycle();
        cmp("fp_one_push", 0, 32'(hs_cnt - hs0), 32'd1);
        cmp("fp_full_again", 0, 32'(s_axis_tready), 32'd0);
        m_axis_tready = 4'b1111;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();

        // Asynchronous reset with 5 entries queued mid-vector.
        do_reset();
        s_axis_tvalid = 1'b1;
        drive_next();
        cycle();
        s_axis_tvalid = 1'b0;
        cycle();
        m_axis_tready = 4'b0000;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_next();
            cycle();
        end
        s_axis_tvalid = 1'b0;
        cycle();
        cmp("rst_pre_valid", 0, 32'(m_axis_tvalid), 32'hf);
        cmp("rst_pre_bcnt", 0, 32'(pos), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_async_valid", 0, 32'(m_axis_tvalid), 32'd0);
        cmp("rst_async_ready", 0, 32'(s_axis_tready), 32'd0);
        cmp("rst_async_last", 0, 32'(m_axis_tlast), 32'd0);
        @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;
        hs_cnt = 0;
        m_axis_tready = 4'b1111;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 2 * VL; i++) begin
            drive_next();
            cycle();
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic against the model, including rare resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata = {$urandom, $urandom};
            s_axis_tlast = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (pos == VL - 1);
            if ((i / 250) % 2 == 0) m_axis_tready = 4'($urandom);
            else m_axis_tready = 4'($urandom) | 4'($urandom);
            cycle();
        end
        rst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 4'b1111;
        for (int i = 0; i < 12; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
